// File: rtl/irq_pend_24.sv
// Interrupt pending/capture stage: synchronises sources, captures edges or levels,
// masks the pending vector for the OR tree and offers a lowest-index claim port.
module irq_pend_24 #(
  parameter int N_SRC       = 24,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_i,
  input  logic [N_SRC-1:0] cfg_edge,
  input  logic [N_SRC-1:0] cfg_en,
  input  logic             clr_vld,
  input  logic [N_SRC-1:0] clr_mask,
  output logic [N_SRC-1:0] pend_o,
  output logic [N_SRC-1:0] irq_masked_o,
  output logic             claim_vld_o,
  output logic [ID_W-1:0]  claim_id_o,
  input  logic             claim_rdy_i
);

  logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;
  logic [N_SRC-1:0]                  s_d_q;
  logic [N_SRC-1:0]                  pend_q;
  logic                              claim_vld_q;
  logic [ID_W-1:0]                   claim_id_q;

  logic [N_SRC-1:0] s_s;
  logic [N_SRC-1:0] set_s;
  logic [N_SRC-1:0] claim_clr_s;
  logic [N_SRC-1:0] clr_s;
  logic [N_SRC-1:0] pend_d;
  logic [N_SRC-1:0] cand_s;
  logic             claim_vld_d;
  logic [ID_W-1:0]  claim_id_d;
  logic             hs_s;

  assign s_s   = sync_q[SYNC_STAGES-1];
  assign set_s = s_s & ~s_d_q;
  assign hs_s  = claim_vld_q & claim_rdy_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
      s_d_q  <= s_s;
    end
  end

  // An accepted claim only clears the claimed bit, and only if it is an edge source.
  always_comb begin
    claim_clr_s = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (hs_s && (claim_id_q == ID_W'(i)) && cfg_edge[i]) begin
        claim_clr_s[i] = 1'b1;
      end else begin
        claim_clr_s[i] = 1'b0;
      end
    end
  end

  assign clr_s = ({N_SRC{clr_vld}} & clr_mask) | claim_clr_s;

  // Edge sources: a new edge beats any clear in the same cycle. Level sources track s.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (cfg_edge[i]) begin
        pend_d[i] = set_s[i] | (pend_q[i] & ~clr_s[i]);
      end else begin
        pend_d[i] = s_s[i];
      end
    end
  end

  assign cand_s = pend_d & cfg_en;

  always_comb begin
    claim_vld_d = 1'b0;
    claim_id_d  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand_s[i]) begin
        claim_vld_d = 1'b1;
        claim_id_d  = ID_W'(i);
      end else begin
        claim_id_d  = claim_id_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      claim_vld_q <= 1'b0;
      claim_id_q  <= '0;
    end else begin
      pend_q      <= pend_d;
      claim_vld_q <= claim_vld_d;
      claim_id_q  <= claim_id_d;
    end
  end

  assign pend_o       = pend_q;
  assign irq_masked_o = pend_q & cfg_en;
  assign claim_vld_o  = claim_vld_q;
  assign claim_id_o   = claim_id_q;

endmodule

// File: tb/tb_irq_pend_24.sv
// Self-checking bench for irq_pend_24: directed test-plan scenarios plus random
// traffic, checked every cycle against a delay-line behavioural model.
module tb_irq_pend_24;
  localparam int N    = 24;
  localparam int SYNC = 2;
  localparam int IDW  = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   src_i = '0;
  logic [N-1:0]   cfg_edge = '1;
  logic [N-1:0]   cfg_en = '1;
  logic           clr_vld = 1'b0;
  logic [N-1:0]   clr_mask = '0;
  logic           claim_rdy_i = 1'b0;
  logic [N-1:0]   pend_o;
  logic [N-1:0]   irq_masked_o;
  logic           claim_vld_o;
  logic [IDW-1:0] claim_id_o;

  int checks = 0;
  int failures = 0;

  irq_pend_24 #(.N_SRC(N), .SYNC_STAGES(SYNC), .ID_W(IDW)) dut (
    .clk(clk), .rst(rst), .src_i(src_i), .cfg_edge(cfg_edge), .cfg_en(cfg_en),
    .clr_vld(clr_vld), .clr_mask(clr_mask), .pend_o(pend_o),
    .irq_masked_o(irq_masked_o), .claim_vld_o(claim_vld_o),
    .claim_id_o(claim_id_o), .claim_rdy_i(claim_rdy_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]   pend;
    logic           vld;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: src history (index 0 = most recent sample) and pending set.
  logic [N-1:0]   m_hist[$];
  logic [N-1:0]   m_pend;
  logic           m_vld;
  logic [IDW-1:0] m_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist = {};
    for (int k = 0; k <= SYNC; k++) m_hist.push_back('0);
    m_pend = '0;
    m_vld  = 1'b0;
    m_id   = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] s_now, s_prev, nxt;
    bit rise, cleared;
    if (rst) begin
      model_reset();
      return;
    end
    s_now  = m_hist[SYNC-1];
    s_prev = m_hist[SYNC];
    nxt    = '0;
    for (int i = 0; i < N; i++) begin
      if (cfg_edge[i]) begin
        rise    = s_now[i] && !s_prev[i];
        cleared = (clr_vld && clr_mask[i]) || (claim_rdy_i && m_vld && (int'(m_id) == i));
        nxt[i]  = rise ? 1'b1 : (cleared ? 1'b0 : m_pend[i]);
      end else begin
        nxt[i]  = s_now[i];
      end
    end
    m_hist.push_front(src_i);
    void'(m_hist.pop_back());
    m_pend = nxt;
    m_vld  = 1'b0;
    m_id   = '0;
    for (int i = 0; i < N; i++) begin
      if (nxt[i] && cfg_en[i] && !m_vld) begin
        m_vld = 1'b1;
        m_id  = IDW'(i);
      end
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    model_edge();
    e.pend = m_pend;
    e.vld  = m_vld;
    e.id   = m_id;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Asserted between edges so reset must take effect without a clock.
  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_pend", 32'(pend_o), 32'd0);
    chk("rst_masked", 32'(irq_masked_o), 32'd0);
    chk("rst_vld", 32'(claim_vld_o), 32'd0);
    chk("rst_id", 32'(claim_id_o), 32'd0);
    step();
    rst = 1'b0;
  endtask

  task automatic quiesce();
    src_i = '0; cfg_edge = '1; cfg_en = '1; claim_rdy_i = 1'b0;
    clr_vld = 1'b1; clr_mask = '1;
    steps(SYNC + 2);
    clr_vld = 1'b0; clr_mask = '0;
    step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_pend", 32'(pend_o), 32'(e.pend));
      chk("sb_masked", 32'(irq_masked_o), 32'(e.pend & cfg_en));
      chk("sb_vld", 32'(claim_vld_o), 32'(e.vld));
      chk("sb_id", 32'(claim_id_o), 32'(e.id));
    end
  end

  initial begin
    logic [N-1:0] r;
    model_reset();
    steps(2);
    chk("init_pend", 32'(pend_o), 32'd0);
    chk("init_vld", 32'(claim_vld_o), 32'd0);
    rst = 1'b0;
    step();

    // Edge capture on src 3
    src_i[3] = 1'b1;
    steps(2);
    chk("edge3_early", 32'(pend_o[3]), 32'd0);
    step();
    chk("edge3_pend", 32'(pend_o[3]), 32'd1);
    chk("edge3_vld", 32'(claim_vld_o), 32'd1);
    chk("edge3_id", 32'(claim_id_o), 32'd3);
    src_i[3] = 1'b0;
    steps(4);
    chk("edge3_hold", 32'(pend_o[3]), 32'd1);
    quiesce();

    // Priority and back-to-back claims
    src_i[2] = 1'b1; src_i[7] = 1'b1; src_i[23] = 1'b1;
    steps(3);
    chk("prio_id0", 32'(claim_id_o), 32'd2);
    claim_rdy_i = 1'b1;
    step();
    chk("prio_id1", 32'(claim_id_o), 32'd7);
    step();
    chk("prio_id2", 32'(claim_id_o), 32'd23);
    step();
    chk("prio_done", 32'(claim_vld_o), 32'd0);
    quiesce();

    // Set beats clear in the same cycle
    src_i[4] = 1'b1;
    steps(2);
    clr_vld = 1'b1; clr_mask = '0; clr_mask[4] = 1'b1;
    step();
    chk("collide", 32'(pend_o[4]), 32'd1);
    step();
    chk("clear4", 32'(pend_o[4]), 32'd0);
    quiesce();

    // Level source ignores claims, follows src
    cfg_edge[10] = 1'b0; src_i[10] = 1'b1;
    steps(3);
    chk("lvl_pend", 32'(pend_o[10]), 32'd1);
    chk("lvl_id", 32'(claim_id_o), 32'd10);
    claim_rdy_i = 1'b1;
    steps(2);
    chk("lvl_claim", 32'(pend_o[10]), 32'd1);
    claim_rdy_i = 1'b0; src_i[10] = 1'b0;
    steps(2);
    chk("lvl_fall_early", 32'(pend_o[10]), 32'd1);
    step();
    chk("lvl_fall", 32'(pend_o[10]), 32'd0);
    quiesce();

    // Mask: disabled source still pends
    cfg_en[0] = 1'b0; src_i[0] = 1'b1;
    steps(3);
    chk("mask_pend", 32'(pend_o[0]), 32'd1);
    chk("mask_irq", 32'(irq_masked_o[0]), 32'd0);
    chk("mask_vld", 32'(claim_vld_o), 32'd0);
    cfg_en[0] = 1'b1;
    #1;
    chk("unmask_irq", 32'(irq_masked_o[0]), 32'd1);
    chk("unmask_vld_lag", 32'(claim_vld_o), 32'd0);
    step();
    chk("unmask_vld", 32'(claim_vld_o), 32'd1);
    quiesce();

    // Reset mid-pend with the source still high
    src_i[5] = 1'b1;
    steps(3);
    chk("pre_rst5", 32'(pend_o[5]), 32'd1);
    do_reset();
    steps(2);
    chk("post_rst5_early", 32'(pend_o[5]), 32'd0);
    step();
    chk("post_rst5", 32'(pend_o[5]), 32'd1);
    quiesce();

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      r = N'($urandom & $urandom & $urandom);
      src_i = src_i ^ r;
      if ($urandom_range(0, 49) == 0) cfg_edge = N'($urandom | $urandom);
      if ($urandom_range(0, 19) == 0) cfg_en = N'($urandom | $urandom);
      clr_vld = ($urandom_range(0, 3) == 0);
      clr_mask = N'($urandom & $urandom);
      claim_rdy_i = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end
    step();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
